// File: rtl/uart_packet_transmitter_if.sv
// Byte-stream input handshake for uart_packet_transmitter.
// The producer (master) offers a byte plus an end-of-packet marker; the
// transmitter (slave) accepts it on any edge where in_valid && in_ready.
interface uart_packet_transmitter_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/uart_packet_transmitter.sv
// Packetised UART transmitter: a byte FIFO feeds an 8N1/8N2 serializer.
// After the final byte of a packet (in_last) the line is held idle for
// GapBits bit periods before the next packet may start.
module uart_packet_transmitter #(
  parameter int ClkFrequency = 100000000,
  parameter int Baud         = 115200,
  parameter int StopBits     = 1,
  parameter int GapBits      = 8,
  parameter int FifoDepth    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  uart_packet_transmitter_if.slave     inBus,
  output logic                         TxD,
  output logic                         TxD_busy,
  output logic [$clog2(FifoDepth):0]   fifo_count
);

  localparam int BitCycles = ClkFrequency / Baud;
  localparam int AddrW     = $clog2(FifoDepth);
  localparam int DivW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;

  // Reject configurations the serializer or FIFO cannot honour.
  generate
    if (BitCycles < 2 || (StopBits != 1 && StopBits != 2) ||
        GapBits < 1 || GapBits > 255 || FifoDepth < 2 ||
        (FifoDepth & (FifoDepth - 1)) != 0) begin : gParamCheck
      $error("uart_packet_transmitter: illegal parameter combination");
    end
  endgenerate

  localparam logic [DivW-1:0]  DivLast   = DivW'(BitCycles - 1);
  localparam logic [7:0]       StopLast  = 8'(StopBits - 1);
  localparam logic [7:0]       GapLast   = 8'(GapBits - 1);
  localparam logic [AddrW:0]   FullCount = (AddrW + 1)'(FifoDepth);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } stateT;

  // ---------------------------------------------------------------- FIFO
  logic [8:0]       fifoMem [FifoDepth];
  logic [AddrW-1:0] wrPtrReg;
  logic [AddrW-1:0] rdPtrReg;
  logic [AddrW:0]   countReg;
  logic             readyReg;
  logic             push;
  logic             pop;
  logic             fifoEmpty;
  logic [8:0]       fifoHead;

  // readyReg keeps in_ready low on reset edges and releases it one edge later.
  assign inBus.in_ready = readyReg && (countReg != FullCount);
  assign push           = inBus.in_valid && inBus.in_ready;
  assign fifoEmpty      = (countReg == '0);
  // Head is read combinationally so IDLE can pop and drive the start bit
  // on the very edge it sees a non-empty FIFO.
  assign fifoHead       = fifoMem[rdPtrReg];

  // Storage write: {last flag, byte} per entry; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtrReg] <= {inBus.in_last, inBus.in_data};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at FifoDepth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      readyReg <= 1'b0;
    end else begin
      readyReg <= 1'b1;
      if (push) begin
        wrPtrReg <= wrPtrReg + 1'b1;
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + 1'b1;
      end
      case ({push, pop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // ---------------------------------------------------------- serializer
  stateT           stateReg,  stateNext;
  logic [DivW-1:0] divReg,    divNext;
  logic [7:0]      bitReg,    bitNext;
  logic [7:0]      shiftReg,  shiftNext;
  logic            lastReg,   lastNext;
  logic            txdReg,    txdNext;
  logic            bitTick;

  assign bitTick = (divReg == DivLast);

  // Serializer state register; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      divReg   <= '0;
      bitReg   <= '0;
      shiftReg <= '0;
      lastReg  <= 1'b0;
      txdReg   <= 1'b1;
    end else begin
      stateReg <= stateNext;
      divReg   <= divNext;
      bitReg   <= bitNext;
      shiftReg <= shiftNext;
      lastReg  <= lastNext;
      txdReg   <= txdNext;
    end
  end

  // Next-state, bit timing and next line level; popping the FIFO head
  // always coincides with entering START and driving the start bit low.
  always_comb begin
    stateNext = stateReg;
    divNext   = bitTick ? '0 : divReg + 1'b1;
    bitNext   = bitReg;
    shiftNext = shiftReg;
    lastNext  = lastReg;
    txdNext   = txdReg;
    pop       = 1'b0;

    case (stateReg)
      IDLE: begin
        divNext = '0;
        txdNext = 1'b1;
        if (!fifoEmpty) begin
          pop       = 1'b1;
          shiftNext = fifoHead[7:0];
          lastNext  = fifoHead[8];
          stateNext = START;
          txdNext   = 1'b0;
        end
      end

      START: begin
        if (bitTick) begin
          stateNext = DATA;
          bitNext   = '0;
          txdNext   = shiftReg[0];
        end
      end

      DATA: begin
        if (bitTick) begin
          if (bitReg == 8'd7) begin
            stateNext = STOP;
            bitNext   = '0;
            txdNext   = 1'b1;
          end else begin
            shiftNext = {1'b0, shiftReg[7:1]};
            bitNext   = bitReg + 1'b1;
            txdNext   = shiftReg[1];
          end
        end
      end

      STOP: begin
        txdNext = 1'b1;
        if (bitTick) begin
          if (bitReg == StopLast) begin
            bitNext = '0;
            if (lastReg) begin
              stateNext = GAP;
            end else if (!fifoEmpty) begin
              // Back-to-back byte: next start bit follows the stop bit directly.
              pop       = 1'b1;
              shiftNext = fifoHead[7:0];
              lastNext  = fifoHead[8];
              stateNext = START;
              txdNext   = 1'b0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            bitNext = bitReg + 1'b1;
          end
        end
      end

      GAP: begin
        txdNext = 1'b1;
        if (bitTick) begin
          if (bitReg == GapLast) begin
            bitNext = '0;
            if (!fifoEmpty) begin
              // Waiting byte starts right as the gap expires, so the
              // inter-packet idle time is exactly GapBits bit periods.
              pop       = 1'b1;
              shiftNext = fifoHead[7:0];
              lastNext  = fifoHead[8];
              stateNext = START;
              txdNext   = 1'b0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            bitNext = bitReg + 1'b1;
          end
        end
      end

      default: begin
        stateNext = IDLE;
        txdNext   = 1'b1;
      end
    endcase
  end

  assign TxD        = txdReg;
  assign TxD_busy   = !fifoEmpty || (stateReg != IDLE);
  assign fifo_count = countReg;

endmodule

// File: tb/tb_uart_packet_transmitter.sv
// Bench for uart_packet_transmitter at 1 MHz / 100 kbaud (10 clocks per bit).
// dut1 uses one stop bit and is decoded against a byte scoreboard;
// dut2 uses two stop bits and is checked on line timing.
module tb_uart_packet_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       txd1, busy1, txd2, busy2;
  logic [4:0] count1, count2;

  int tests = 0;
  int fails = 0;

  uart_packet_transmitter_if bus1 ();
  uart_packet_transmitter_if bus2 ();

  uart_packet_transmitter #(
    .ClkFrequency(1000000), .Baud(100000), .StopBits(1), .GapBits(8), .FifoDepth(16)
  ) dut1 (
    .clk(clk), .reset(reset), .inBus(bus1.slave),
    .TxD(txd1), .TxD_busy(busy1), .fifo_count(count1)
  );

  uart_packet_transmitter #(
    .ClkFrequency(1000000), .Baud(100000), .StopBits(2), .GapBits(8), .FifoDepth(16)
  ) dut2 (
    .clk(clk), .reset(reset), .inBus(bus2.slave),
    .TxD(txd2), .TxD_busy(busy2), .fifo_count(count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ monitors
  logic [7:0] sb[$];        // bytes accepted by dut1, in order
  int         starts1[$];   // cycle at which each dut1 frame began
  int         falls2[$];    // cycle of each dut2 falling edge
  int         runs2[$];     // high-run length preceding each dut2 fall
  int         cyc = 0;
  bit         monActive = 0;
  int         monCnt = 0;
  logic [7:0] monShift = '0;
  int         frameNo = 0;
  int         highRun2 = 0;
  logic       txd2Prev = 1'b1;

  // Sample 1 time unit after each rising edge; decode dut1 frames mid-bit.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      monActive = 0;
      sb.delete();
      highRun2  = 0;
      txd2Prev  = 1'b1;
    end else begin
      if (!monActive) begin
        if (txd1 == 1'b0) begin
          monActive = 1;
          monCnt    = 0;
          monShift  = '0;
          starts1.push_back(cyc);
        end
      end else begin
        monCnt++;
      end
      if (monActive) begin
        if (monCnt == 5) begin
          check("start_bit", int'(txd1), 0);
        end else if (monCnt >= 15 && monCnt <= 85 && (monCnt % 10) == 5) begin
          monShift = {txd1, monShift[7:1]};
        end else if (monCnt == 95) begin
          check("stop_bit", int'(txd1), 1);
          if (sb.size() == 0) begin
            check("unexpected_frame", int'(monShift), -1);
          end else begin
            logic [7:0] exp;
            exp = sb.pop_front();
            $display("[TB] frame %0d: got 0x%02h expected 0x%02h", frameNo, monShift, exp);
            check("frame_data", int'(monShift), int'(exp));
          end
          frameNo++;
          monActive = 0;
        end
      end
      if (txd2) begin
        highRun2++;
      end else if (txd2Prev) begin
        falls2.push_back(cyc);
        runs2.push_back(highRun2);
        highRun2 = 0;
      end
      txd2Prev = txd2;
    end
  end

  // ------------------------------------------------------------- helpers
  task automatic pushByte(input int sel, input logic [7:0] d, input logic l, output bit acc);
    if (sel == 1) begin
      bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = l;
      acc = bus1.in_ready;
    end else begin
      bus2.in_valid = 1'b1; bus2.in_data = d; bus2.in_last = l;
      acc = bus2.in_ready;
    end
    @(negedge clk);
    if (acc && sel == 1) sb.push_back(d);
  endtask

  task automatic waitIdle(input int sel, input int limit, output int n);
    n = 0;
    while (((sel == 1) ? busy1 : busy2) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         expBusy;  // cycles from TxD falling to TxD_busy falling
  } vec_t;

  vec_t vecs[5];

  // Watchdog: never let the bench hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int n, peak, guard, bad, i;
    bit sawFull;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b0, 100};
    vecs[1] = '{8'h3C, 1'b0, 100};
    vecs[2] = '{8'h00, 1'b1, 180};
    vecs[3] = '{8'hFF, 1'b0, 100};
    vecs[4] = '{8'h81, 1'b1, 180};

    bus1.in_valid = 0; bus1.in_data = 0; bus1.in_last = 0;
    bus2.in_valid = 0; bus2.in_data = 0; bus2.in_last = 0;
    reset = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_txd",   int'(txd1), 1);
    check("rst_count", int'(count1), 0);
    check("rst_busy",  int'(busy1), 0);
    check("rst_ready", int'(bus1.in_ready), 0);
    check("rst_txd2",  int'(txd2), 1);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", int'(bus1.in_ready), 1);

    // Single-byte frames from the table: latency, frame length, gap length.
    for (int v = 0; v < 5; v++) begin
      pushByte(1, vecs[v].data, vecs[v].last, acc);
      bus1.in_valid = 0;
      check("vec_accepted", int'(acc), 1);
      check("vec_pre_txd", int'(txd1), 1);
      check("vec_count", int'(count1), 1);
      @(negedge clk);
      check("vec_latency_txd", int'(txd1), 0);
      waitIdle(1, 2000, n);
      check("vec_busy_len", n, vecs[v].expBusy);
    end

    // Three back-to-back bytes: contiguous frames, FIFO peaks at 2.
    starts1.delete();
    peak = 0;
    pushByte(1, 8'h11, 1'b0, acc); if (int'(count1) > peak) peak = int'(count1);
    pushByte(1, 8'h22, 1'b0, acc); if (int'(count1) > peak) peak = int'(count1);
    pushByte(1, 8'h33, 1'b0, acc); if (int'(count1) > peak) peak = int'(count1);
    bus1.in_valid = 0;
    waitIdle(1, 2000, n);
    check("b2b_peak", peak, 2);
    // One cycle of the 300 had already elapsed when counting began.
    check("b2b_busy_len", n, 299);
    check("b2b_frames", starts1.size(), 3);
    if (starts1.size() == 3) begin
      check("b2b_gap01", starts1[1] - starts1[0], 100);
      check("b2b_gap12", starts1[2] - starts1[1], 100);
    end

    // Packet end then a new byte: start waits out the 80-cycle gap.
    starts1.delete();
    pushByte(1, 8'h00, 1'b1, acc);
    pushByte(1, 8'hFF, 1'b0, acc);
    bus1.in_valid = 0;
    waitIdle(1, 3000, n);
    check("gap_idle_reached", int'(n < 3000), 1);
    check("gap_frames", starts1.size(), 2);
    if (starts1.size() == 2) begin
      check("gap_start_spacing", starts1[1] - starts1[0], 180);
    end

    // Streaming 20 bytes with in_valid held high: backpressure at 16.
    i = 0; guard = 0; bad = 0; sawFull = 0;
    while (i < 20 && guard < 5000) begin
      d = 8'(i * 37 + 5);
      bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = 1'b0;
      acc = bus1.in_ready;
      if (count1 == 5'd16) sawFull = 1;
      if (acc != (count1 != 5'd16)) bad++;
      @(negedge clk);
      guard++;
      if (acc) begin
        sb.push_back(d);
        i++;
      end
    end
    bus1.in_valid = 0;
    check("stream_accepted", i, 20);
    check("stream_saw_full", int'(sawFull), 1);
    check("stream_ready_rule", bad, 0);
    waitIdle(1, 30000, n);
    check("stream_idle_reached", int'(n < 30000), 1);
    check("stream_drained", sb.size(), 0);

    // Two stop bits: 110-cycle frames with a 20-cycle high between them.
    falls2.delete(); runs2.delete();
    pushByte(2, 8'h00, 1'b0, acc);
    pushByte(2, 8'h00, 1'b0, acc);
    bus2.in_valid = 0;
    waitIdle(2, 2000, n);
    check("sb2_busy_len", n, 220);
    check("sb2_falls", falls2.size(), 2);
    if (falls2.size() == 2) begin
      check("sb2_frame_len", falls2[1] - falls2[0], 110);
      check("sb2_high_between", runs2[1], 20);
    end

    // Reset mid-DATA with three bytes queued, then a clean frame.
    pushByte(1, 8'h12, 1'b0, acc);
    pushByte(1, 8'h34, 1'b0, acc);
    pushByte(1, 8'h56, 1'b0, acc);
    pushByte(1, 8'h78, 1'b0, acc);
    bus1.in_valid = 0;
    check("abort_queued", int'(count1), 3);
    repeat (25) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_txd", int'(txd1), 1);
    check("abort_count", int'(count1), 0);
    check("abort_busy", int'(busy1), 0);
    check("abort_ready", int'(bus1.in_ready), 0);
    @(negedge clk);
    check("abort_ready_back", int'(bus1.in_ready), 1);
    pushByte(1, 8'h5A, 1'b0, acc);
    bus1.in_valid = 0;
    @(negedge clk);
    check("abort_new_txd", int'(txd1), 0);
    waitIdle(1, 2000, n);
    check("abort_new_busy", n, 100);
    check("abort_new_drained", sb.size(), 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
